// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point types and widths for the neuron datapath.
// Q6.7 words, wide accumulators and the MAC sequencer state encoding.
package nn_fixed_pkg;

    localparam int DEF_INT_BITS = 6;
    localparam int DEF_FRC_BITS = 7;
    localparam int DEF_N_INPUTS = 32;

    localparam int W = DEF_INT_BITS + DEF_FRC_BITS;

    // Sized so that N full-scale products can never wrap the sum.
    function automatic int acc_width(input int n);
        return 2 * W + $clog2(n);
    endfunction

    localparam int ACC_W = acc_width(DEF_N_INPUTS);

    typedef logic signed [W-1:0] fx_t;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        MAC,
        FINAL,
        DONE
    } mac_state_t;

endpackage

// File: rtl/fx_round_sat.sv
// Round-half-up and saturate a wide accumulator back to a Q6.7 word.
// Purely combinational; shared by every layer that narrows a sum.
module fx_round_sat
    import nn_fixed_pkg::*;
#(
    parameter int IN_W = ACC_W,
    parameter int FRC  = DEF_FRC_BITS
) (
    input  logic signed [IN_W-1:0] acc,
    output fx_t                    y,
    output logic                   ovf
);

    localparam logic signed [IN_W-1:0] HALF = IN_W'(1) << (FRC - 1);
    localparam logic signed [IN_W-1:0] MAXV =
        {{(IN_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MINV =
        {{(IN_W-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [IN_W-1:0] sum;
    logic signed [IN_W-1:0] shr;

    always_comb begin
        sum = acc + HALF;
        shr = sum >>> FRC;
        y   = shr[W-1:0];
        ovf = 1'b0;
        if (shr > MAXV) begin
            y   = MAXV[W-1:0];
            ovf = 1'b1;
        end else if (shr < MINV) begin
            y   = MINV[W-1:0];
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Weight-ROM sequencer and MAC for one neuron: streams N_INPUTS
// activation/weight products into a wide sum and emits a Q6.7 result.
module neuron_mac_seq
    import nn_fixed_pkg::*;
#(
    parameter int N_INPUTS = DEF_N_INPUTS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [W-1:0] x_data,
    input  logic                x_valid,
    output logic                x_ready,
    output logic [4:0]          rom_addr,
    input  logic signed [W-1:0] rom_dout,
    output logic signed [W-1:0] y_data,
    output logic                y_valid,
    input  logic                y_ready,
    output logic                y_ovf,
    output logic                busy
);

    localparam int         AW   = acc_width(N_INPUTS);
    localparam logic [4:0] LAST = 5'(N_INPUTS - 1);

    mac_state_t           state_q, state_d;
    logic [4:0]           idx_q, idx_d;
    logic signed [AW-1:0] acc_q, acc_d;
    fx_t                  y_data_q, y_data_d;
    logic                 y_ovf_q, y_ovf_d;

    logic signed [2*W-1:0] prod;
    fx_t                   rs_y;
    logic                  rs_ovf;

    assign prod = x_data * rom_dout;

    fx_round_sat #(
        .IN_W (AW),
        .FRC  (DEF_FRC_BITS)
    ) u_round_sat (
        .acc (acc_q),
        .y   (rs_y),
        .ovf (rs_ovf)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        y_data_d = y_data_q;
        y_ovf_d  = y_ovf_q;
        x_ready  = 1'b0;
        rom_addr = '0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = PRIME;
            end
            PRIME: begin
                state_d = MAC;
            end
            MAC: begin
                x_ready  = 1'b1;
                rom_addr = idx_q;
                if (x_valid) begin
                    acc_d = acc_q + AW'(prod);
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = FINAL;
                    end else begin
                        // Look ahead so the next weight lands with the next beat.
                        idx_d    = idx_q + 5'd1;
                        rom_addr = idx_q + 5'd1;
                    end
                end
            end
            FINAL: begin
                y_data_d = rs_y;
                y_ovf_d  = rs_ovf;
                acc_d    = '0;
                state_d  = DONE;
            end
            DONE: begin
                if (y_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            y_data_q <= '0;
            y_ovf_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            y_data_q <= y_data_d;
            y_ovf_q  <= y_ovf_d;
        end
    end

    assign y_data  = y_data_q;
    assign y_ovf   = y_ovf_q;
    assign y_valid = (state_q == DONE);
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq with a 1-cycle registered ROM model.
// Expected results are hand-computed Q6.7 values.
module tb_neuron_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [12:0] x_data = '0;
    logic        x_valid = 1'b0;
    logic        x_ready;
    logic [4:0]  rom_addr;
    logic [12:0] rom_dout = '0;
    logic [12:0] y_data;
    logic        y_valid;
    logic        y_ready = 1'b0;
    logic        y_ovf;
    logic        busy;

    logic [12:0] rom_mem [32];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom_mem[rom_addr];

    neuron_mac_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x_data   (x_data),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .y_data   (y_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_ovf    (y_ovf),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [12:0] w);
        for (int i = 0; i < 32; i++) rom_mem[i] = w;
    endtask

    task automatic run_dot(input string tag, input logic [12:0] xv,
                           input bit gaps, input int hold,
                           input logic [12:0] ey, input logic eo);
        int          beats;
        int          addr_err;
        int          cyc;
        int          exp_addr;
        bit          hold_ok;
        logic [12:0] yh;
        logic        oh;
        beats    = 0;
        addr_err = 0;
        cyc      = 0;
        hold_ok  = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".prime_xr"}, x_ready, 0);
        chk({tag, ".prime_busy"}, busy, 1);
        while (beats < 32 && cyc < 2000) begin
            @(negedge clk);
            x_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            x_data  = xv;
            #1;
            if (cyc == 0) chk({tag, ".mac_xr"}, x_ready, 1);
            if (x_ready && x_valid) begin
                exp_addr = (beats == 31) ? 31 : beats + 1;
                if (rom_addr !== 5'(exp_addr)) addr_err++;
                beats++;
            end else if (rom_addr !== 5'(beats)) begin
                addr_err++;
            end
            cyc++;
        end
        chk({tag, ".beats"}, beats, 32);
        chk({tag, ".addr_err"}, addr_err, 0);
        @(negedge clk);
        x_valid = 1'b0;
        x_data  = '0;
        chk({tag, ".final_xr"}, x_ready, 0);
        chk({tag, ".final_yv"}, y_valid, 0);
        @(negedge clk);
        chk({tag, ".yv"}, y_valid, 1);
        chk({tag, ".y"}, y_data, ey);
        chk({tag, ".ovf"}, y_ovf, eo);
        yh = y_data;
        oh = y_ovf;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            start = (h % 3 == 0);
            #1;
            if (y_valid !== 1'b1 || y_data !== yh ||
                y_ovf !== oh || x_ready !== 1'b0) hold_ok = 1'b0;
        end
        if (hold > 0) chk({tag, ".hold"}, hold_ok, 1);
        @(negedge clk);
        y_ready = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        y_ready = 1'b0;
        start   = 1'b0;
        chk({tag, ".idle_busy"}, busy, 0);
        chk({tag, ".idle_yv"}, y_valid, 0);
        @(negedge clk);
        chk({tag, ".start_ignored"}, busy, 0);
    endtask

    initial begin
        fill(13'h0000);
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.xr", x_ready, 0);
        chk("rst.yv", y_valid, 0);
        chk("rst.y", y_data, 0);
        chk("rst.ovf", y_ovf, 0);
        chk("rst.addr", rom_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        fill(13'h0040);
        run_dot("t1", 13'h0080, 1'b0, 0, 13'h0800, 1'b0);

        fill(13'h0080);
        run_dot("t2pos", 13'h0080, 1'b0, 0, 13'h0FFF, 1'b1);
        // -32.0 is exactly representable, so it is not a clip.
        fill(13'h1F80);
        run_dot("t2neg", 13'h0080, 1'b0, 0, 13'h1000, 1'b0);
        run_dot("t2clip", 13'h0100, 1'b0, 0, 13'h1000, 1'b1);

        fill(13'h0000);
        rom_mem[0] = 13'h0001;
        run_dot("t3pos", 13'h0040, 1'b0, 0, 13'h0001, 1'b0);
        run_dot("t3neg", 13'h1FC0, 1'b0, 0, 13'h0000, 1'b0);

        fill(13'h0040);
        run_dot("t4", 13'h0080, 1'b1, 0, 13'h0800, 1'b0);
        run_dot("t5", 13'h0080, 1'b0, 10, 13'h0800, 1'b0);
        run_dot("t5b", 13'h0080, 1'b0, 0, 13'h0800, 1'b0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            x_valid = 1'b1;
            x_data  = 13'h0080;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.busy", busy, 0);
        chk("t6.xr", x_ready, 0);
        chk("t6.yv", y_valid, 0);
        chk("t6.y", y_data, 0);
        chk("t6.ovf", y_ovf, 0);
        chk("t6.addr", rom_addr, 0);
        x_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_dot("t6run", 13'h0080, 1'b0, 0, 13'h0800, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
